burst_rr_arbiter: RTL and testbench

- Parametrised N-channel round-robin arbiter that merges 32-bit words from per-channel first-word-fall-through FIFOs (FE receivers, TDC, TLU) into a single registered stream for the SRAM FIFO.
- Successor to the fixed single-word arbiter. It adds:
  - configurable channel count and data width;
  - a runtime channel-enable mask;
  - bounded bursts per grant;
  - hold (preempt) priority;
  - a channel index on the output.

---
 rtl/burst_rr_arbiter.sv | 127 ++++++++++++
 tb/tb_burst_rr_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/burst_rr_arbiter.sv
// burst_rr_arbiter: merges N first-word-fall-through channel FIFOs into one
// registered output stream. Round-robin between channels, bounded bursts per
// grant, hold priority that overrides the burst limit, and a runtime enable mask.
//
// state | meaning
// IDLE  | no channel owned; pick a winner from the eligible channels
// GRANT | cur_ch owned; pop into the output register whenever it can take a word
module burst_rr_arbiter #(
  parameter int WIDTH      = 6,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 16,
  localparam int CH_BITS   = (WIDTH > 1) ? $clog2(WIDTH) : 1,
  localparam int BC_BITS   = $clog2(MAX_BURST + 1)
) (
  input  logic                        BUS_CLK,
  input  logic                        BUS_RST,
  input  logic [WIDTH-1:0]            CH_EN,
  input  logic [WIDTH-1:0]            WRITE_REQ,
  input  logic [WIDTH-1:0]            HOLD_REQ,
  input  logic [WIDTH*DATA_WIDTH-1:0] DATA_IN,
  output logic [WIDTH-1:0]            READ_GRANT,
  input  logic                        OUT_READY,
  output logic                        OUT_VALID,
  output logic [DATA_WIDTH-1:0]       OUT_DATA,
  output logic [CH_BITS-1:0]          OUT_CH,
  output logic                        BUSY
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state;
  logic [CH_BITS-1:0] cur_ch;
  logic [CH_BITS-1:0] ptr;
  logic [CH_BITS-1:0] sel_ch;
  logic [BC_BITS-1:0] bcnt;
  logic [WIDTH-1:0]   eligible;
  logic [WIDTH-1:0]   hold_elig;
  logic               sel_found;
  logic               load;
  logic               burst_done;
  logic               leave;
  int                 rr_best;
  int                 rr_dist;

  assign eligible  = WRITE_REQ & CH_EN;
  assign hold_elig = eligible & HOLD_REQ;

  // A pop is suppressed during reset so no word leaves a FIFO only to be discarded.
  assign load = (state == GRANT) & ~BUS_RST & WRITE_REQ[cur_ch] & CH_EN[cur_ch] &
                (~OUT_VALID | OUT_READY);

  assign burst_done = (load && (bcnt == BC_BITS'(MAX_BURST - 1))) ||
                      (bcnt == BC_BITS'(MAX_BURST));

  // Disable always wins; otherwise hold keeps the grant through empty cycles and long bursts.
  assign leave = ~CH_EN[cur_ch] | (~HOLD_REQ[cur_ch] & (~WRITE_REQ[cur_ch] | burst_done));

  assign BUSY = (state == GRANT);

  // Winner selection: lowest eligible holder first, else nearest eligible channel after ptr.
  always_comb begin
    sel_found = 1'b0;
    sel_ch    = '0;
    rr_best   = WIDTH;
    rr_dist   = 0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (hold_elig[i]) begin
        sel_found = 1'b1;
        sel_ch    = CH_BITS'(i);
      end
    end
    if (!sel_found) begin
      for (int i = 0; i < WIDTH; i++) begin
        rr_dist = (i + 2 * WIDTH - int'(ptr) - 1) % WIDTH;
        if (eligible[i] && (rr_dist < rr_best)) begin
          rr_best   = rr_dist;
          sel_found = 1'b1;
          sel_ch    = CH_BITS'(i);
        end
      end
    end
  end

  // Pop strobe to the owning channel, same cycle as the output register load.
  always_comb begin
    READ_GRANT = '0;
    if (load) READ_GRANT[cur_ch] = 1'b1;
  end

  // Ownership FSM, burst counter and output register.
  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      state     <= IDLE;
      cur_ch    <= '0;
      ptr       <= CH_BITS'(WIDTH - 1);
      bcnt      <= '0;
      OUT_VALID <= 1'b0;
      OUT_DATA  <= '0;
      OUT_CH    <= '0;
    end else begin
      if (load) begin
        OUT_VALID <= 1'b1;
        OUT_DATA  <= DATA_IN[int'(cur_ch) * DATA_WIDTH +: DATA_WIDTH];
        OUT_CH    <= cur_ch;
      end else if (OUT_READY && OUT_VALID) begin
        OUT_VALID <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (sel_found) begin
            state  <= GRANT;
            cur_ch <= sel_ch;
            ptr    <= sel_ch;
            bcnt   <= '0;
          end
        end
        GRANT: begin
          if (load && (bcnt != BC_BITS'(MAX_BURST))) bcnt <= bcnt + BC_BITS'(1);
          if (leave) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_burst_rr_arbiter.sv
// Bench for burst_rr_arbiter: a directed table, hand-written corner sequences and
// a randomized run, all against a cycle-level reference model and a per-channel
// word-order scoreboard.
module tb_burst_rr_arbiter;
  localparam int W   = 6;
  localparam int DW  = 32;
  localparam int MB  = 4;
  localparam int CHB = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [W-1:0]    ch_en, wreq, hold, rg, avail;
  logic [W*DW-1:0] din;
  logic            ordy, ovalid, busy;
  logic [DW-1:0]   odata;
  logic [CHB-1:0]  och;

  burst_rr_arbiter #(.WIDTH(W), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .BUS_CLK(clk), .BUS_RST(rst), .CH_EN(ch_en), .WRITE_REQ(wreq), .HOLD_REQ(hold),
    .DATA_IN(din), .READ_GRANT(rg), .OUT_READY(ordy), .OUT_VALID(ovalid),
    .OUT_DATA(odata), .OUT_CH(och), .BUSY(busy)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] fifo [W][$];
  logic [DW-1:0] expq [W][$];
  int seqno [W];
  int pops [W];
  int pop_log [$];

  int            m_owner = -1;
  int            m_ptr   = W - 1;
  int            m_cnt   = 0;
  int            m_ch    = 0;
  logic          m_ov    = 1'b0;
  logic [DW-1:0] m_data  = '0;
  logic          m_load, m_leave;
  logic [W-1:0]  m_rg;

  logic [W-1:0]   s_rg;
  logic           s_busy, s_ov;
  logic [CHB-1:0] s_ch;
  logic [DW-1:0]  s_data;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct packed {
    logic           rdy;
    logic [W-1:0]   rg;
    logic           busy;
    logic           ov;
    logic [CHB-1:0] ch;
    logic [DW-1:0]  data;
  } vec_t;
  vec_t tbl [11];

  function automatic logic [DW-1:0] word(input int ch, input int k);
    return {8'(ch), 24'(k)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  task automatic push_words(input int ch, input int n);
    for (int k = 0; k < n; k++) begin
      fifo[ch].push_back(word(ch, seqno[ch]));
      seqno[ch]++;
    end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < W; i++) begin
      wreq[i] = avail[i] && (fifo[i].size() > 0);
      din[i*DW +: DW] = (fifo[i].size() > 0) ? fifo[i][0] : '0;
    end
  endtask

  // Expected pop and exit decision for the current cycle, from the arbitration rules.
  task automatic model_comb();
    int cnt_next;
    m_rg    = '0;
    m_load  = 1'b0;
    m_leave = 1'b0;
    if (m_owner >= 0) begin
      m_load = !rst && wreq[m_owner] && ch_en[m_owner] && (!m_ov || ordy);
      if (m_load) m_rg[m_owner] = 1'b1;
      cnt_next = m_load ? ((m_cnt + 1 > MB) ? MB : m_cnt + 1) : m_cnt;
      m_leave = !ch_en[m_owner] || (!hold[m_owner] && (!wreq[m_owner] || cnt_next >= MB));
    end
  endtask

  // Advance the model across a clock edge.
  task automatic model_seq();
    int win;
    int idx;
    if (rst) begin
      if (m_ov && !ordy && expq[m_ch].size() > 0) void'(expq[m_ch].pop_back());
      m_owner = -1; m_ptr = W - 1; m_cnt = 0; m_ov = 1'b0; m_data = '0; m_ch = 0;
      return;
    end
    if (m_owner >= 0) begin
      if (m_load) begin
        m_data = fifo[m_owner].pop_front();
        m_ch   = m_owner;
        m_ov   = 1'b1;
        expq[m_owner].push_back(m_data);
        if (m_cnt < MB) m_cnt++;
      end else if (m_ov && ordy) begin
        m_ov = 1'b0;
      end
      if (m_leave) m_owner = -1;
    end else begin
      if (m_ov && ordy) m_ov = 1'b0;
      win = -1;
      for (int i = 0; i < W; i++)
        if (win < 0 && hold[i] && wreq[i] && ch_en[i]) win = i;
      if (win < 0) begin
        for (int k = 1; k <= W; k++) begin
          idx = (m_ptr + k) % W;
          if (win < 0 && wreq[idx] && ch_en[idx]) win = idx;
        end
      end
      if (win >= 0) begin
        m_owner = win; m_ptr = win; m_cnt = 0;
      end
    end
  endtask

  task automatic cycle(input bit do_chk);
    drive_inputs();
    #2;
    model_comb();
    s_rg = rg; s_busy = busy; s_ov = ovalid; s_ch = och; s_data = odata;
    if (do_chk)
      chk("cycle", 64'({s_rg, s_busy, s_ov, m_ov ? s_ch : 3'd0, m_ov ? s_data : 32'd0}),
                   64'({m_rg, (m_owner >= 0), m_ov, m_ov ? 3'(m_ch) : 3'd0, m_ov ? m_data : 32'd0}));
    for (int i = 0; i < W; i++) begin
      if (s_rg[i] === 1'b1) begin
        pops[i]++;
        pop_log.push_back(i);
      end
    end
    @(posedge clk);
    if (do_chk && s_ov === 1'b1 && ordy) begin
      if (int'(s_ch) < W && expq[s_ch].size() > 0) begin
        chk("order", 64'(s_data), 64'(expq[s_ch][0]));
        void'(expq[s_ch].pop_front());
      end else begin
        n_vec++;
        n_bad++;
        $display("FAIL order: got word %0h on ch %0d, expected no word", s_data, s_ch);
      end
    end
    model_seq();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; ch_en = '1; hold = '0; ordy = 1'b1; avail = '1;
    cycle(1'b0);
    rst = 1'b0;
    for (int i = 0; i < W; i++) begin
      fifo[i].delete(); expq[i].delete(); seqno[i] = 0; pops[i] = 0;
    end
    pop_log.delete();
    drive_inputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int exp_seq [20];
    int lat;
    int rc;
    logic [DW-1:0] held;
    logic [W-1:0] rbits;

    rst = 1'b1; ch_en = '1; hold = '0; ordy = 1'b1; avail = '1; wreq = '0; din = '0;
    @(posedge clk); #1;

    // Reset values and the two-burst table.
    do_reset();
    #1;
    chk("reset_vals", 64'({ovalid, busy, rg, och, odata}), 64'(0));
    push_words(2, 3);
    push_words(4, 3);
    tbl[0]  = '{1'b1, 6'h00, 1'b0, 1'b0, 3'd0, 32'h0};
    tbl[1]  = '{1'b1, 6'h04, 1'b1, 1'b0, 3'd0, 32'h0};
    tbl[2]  = '{1'b1, 6'h04, 1'b1, 1'b1, 3'd2, 32'h0200_0000};
    tbl[3]  = '{1'b1, 6'h04, 1'b1, 1'b1, 3'd2, 32'h0200_0001};
    tbl[4]  = '{1'b1, 6'h00, 1'b1, 1'b1, 3'd2, 32'h0200_0002};
    tbl[5]  = '{1'b1, 6'h00, 1'b0, 1'b0, 3'd0, 32'h0};
    tbl[6]  = '{1'b1, 6'h10, 1'b1, 1'b0, 3'd0, 32'h0};
    tbl[7]  = '{1'b1, 6'h10, 1'b1, 1'b1, 3'd4, 32'h0400_0000};
    tbl[8]  = '{1'b1, 6'h10, 1'b1, 1'b1, 3'd4, 32'h0400_0001};
    tbl[9]  = '{1'b1, 6'h00, 1'b1, 1'b1, 3'd4, 32'h0400_0002};
    tbl[10] = '{1'b1, 6'h00, 1'b0, 1'b0, 3'd0, 32'h0};
    for (int i = 0; i < 11; i++) begin
      ordy = tbl[i].rdy;
      cycle(1'b1);
      chk("t1_grant", 64'(s_rg), 64'(tbl[i].rg));
      chk("t1_busy_valid", 64'({s_busy, s_ov}), 64'({tbl[i].busy, tbl[i].ov}));
      if (tbl[i].ov) chk("t1_ch_data", 64'({s_ch, s_data}), 64'({tbl[i].ch, tbl[i].data}));
    end

    // Two long channels alternate in bursts of MB.
    do_reset();
    push_words(0, 10);
    push_words(1, 10);
    exp_seq = '{0,0,0,0,1,1,1,1,0,0,0,0,1,1,1,1,0,0,1,1};
    for (int c = 0; c < 200 && pop_log.size() < 20; c++) cycle(1'b1);
    for (int c = 0; c < 4; c++) cycle(1'b1);
    chk("t2_pop_count", 64'(pop_log.size()), 64'(20));
    for (int i = 0; i < 20 && i < pop_log.size(); i++)
      chk("t2_burst_seq", 64'(pop_log[i]), 64'(exp_seq[i]));

    // Hold keeps channel 0 beyond the burst limit and while it is empty.
    do_reset();
    hold = 6'b000001;
    push_words(0, 20);
    push_words(3, 3);
    for (int c = 0; c < 24; c++) begin
      avail[0] = ((c / 3) % 2) == 0;
      cycle(1'b1);
    end
    chk("t3_held_beyond_limit", 64'(pops[0] > MB), 64'(1));
    chk("t3_no_preempt", 64'(pops[3]), 64'(0));
    hold = '0;
    avail[0] = 1'b1;
    lat = -1;
    for (int c = 0; c < 10 && lat < 0; c++) begin
      cycle(1'b1);
      if (s_rg[3] === 1'b1) lat = c;
    end
    chk("t3_release_latency", 64'(lat >= 0 && lat <= 2), 64'(1));

    // Output stall mid-burst.
    do_reset();
    push_words(1, 8);
    for (int c = 0; c < 10 && pops[1] < 2; c++) cycle(1'b1);
    ordy = 1'b0;
    cycle(1'b1);
    held = s_data;
    chk("t4_held_word", 64'(held), 64'(32'h0100_0001));
    chk("t4_stall_grant", 64'(s_rg), 64'(0));
    for (int c = 0; c < 4; c++) begin
      cycle(1'b1);
      chk("t4_stall_grant", 64'(s_rg), 64'(0));
      chk("t4_stall_data", 64'({s_ov, s_data}), 64'({1'b1, held}));
    end
    ordy = 1'b1;
    cycle(1'b1);
    chk("t4_resume_grant", 64'(s_rg), 64'(6'b000010));
    cycle(1'b1);
    chk("t4_next_word", 64'(s_data), 64'(32'h0100_0002));
    for (int c = 0; c < 12; c++) cycle(1'b1);

    // Disable a held channel mid-burst.
    do_reset();
    hold = 6'b000010;
    push_words(1, 10);
    push_words(2, 3);
    for (int c = 0; c < 20 && pops[1] < 3; c++) cycle(1'b1);
    ch_en[1] = 1'b0;
    cycle(1'b1);
    chk("t5_no_pop_disabled", 64'(s_rg), 64'(0));
    cycle(1'b1);
    chk("t5_idle_after_disable", 64'(s_busy), 64'(0));
    for (int c = 0; c < 10; c++) cycle(1'b1);
    chk("t5_ch1_pops", 64'(pops[1]), 64'(3));
    chk("t5_ch2_pops", 64'(pops[2]), 64'(3));

    // Reset in the middle of a burst.
    do_reset();
    push_words(3, 8);
    for (int c = 0; c < 20 && pops[3] < 2; c++) cycle(1'b1);
    push_words(0, 4);
    rst = 1'b1;
    cycle(1'b1);
    rst = 1'b0;
    cycle(1'b1);
    chk("t6_after_reset", 64'({s_ov, s_rg, s_busy}), 64'(0));
    pop_log.delete();
    for (int c = 0; c < 10 && pop_log.size() == 0; c++) cycle(1'b1);
    chk("t6_first_after_reset", 64'(pop_log.size() > 0 ? pop_log[0] : -1), 64'(0));

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(3, 0) == 0) begin
        rc = $urandom_range(W - 1, 0);
        if (fifo[rc].size() < 6) push_words(rc, 1);
      end
      if ($urandom_range(29, 0) == 0) begin
        rc = $urandom_range(W - 1, 0);
        ch_en[rc] = ~ch_en[rc];
      end
      if ($urandom_range(39, 0) == 0) begin
        rbits = '0;
        rc = $urandom_range(W - 1, 0);
        rbits[rc] = 1'b1;
        hold = ($urandom_range(2, 0) == 0) ? rbits : '0;
      end
      ordy = ($urandom_range(3, 0) != 0);
      for (int i = 0; i < W; i++) avail[i] = ($urandom_range(7, 0) != 0);
      rst = ($urandom_range(399, 0) == 0);
      cycle(1'b1);
    end

    // Drain everything and confirm nothing was lost.
    rst = 1'b0; ch_en = '1; hold = '0; ordy = 1'b1; avail = '1;
    for (int c = 0; c < 300; c++) cycle(1'b1);
    rc = 0;
    for (int i = 0; i < W; i++) rc += fifo[i].size() + expq[i].size();
    chk("drain_left", 64'(rc), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
